// File: rtl/feistel_engine.sv
// rtl/feistel_engine.sv - iterative Feistel round engine sequencing single or triple (EDE) passes
module feistel_engine #(
    parameter int HALF_W = 32,
    parameter int ROUNDS = 16,
    parameter int RND_W  = $clog2(ROUNDS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*HALF_W-1:0] in_block,
    input  logic                is_enc,
    input  logic                tdes,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*HALF_W-1:0] out_block,
    output logic [RND_W-1:0]    ks_round,
    output logic [1:0]          ks_key_sel,
    output logic                ks_dec,
    output logic [HALF_W-1:0]   f_r,
    input  logic [HALF_W-1:0]   f_out,
    output logic                busy
);
    typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_DONE} state_t;

    localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);

    state_t            state_q, state_d;
    logic [HALF_W-1:0] l_q, l_d;
    logic [HALF_W-1:0] r_q, r_d;
    logic [RND_W-1:0]  rnd_q, rnd_d;
    logic [1:0]        pass_q, pass_d;
    logic              enc_q, enc_d;
    logic              tdes_q, tdes_d;

    logic              pass_enc;
    logic              last_rnd;
    logic              last_pass;

    // EDE flips direction only on the middle pass; decrypt walks the keys backwards
    always_comb begin
        pass_enc  = tdes_q ? (enc_q ^ (pass_q == 2'd1)) : enc_q;
        last_rnd  = (rnd_q == LAST_RND);
        last_pass = tdes_q ? (pass_q == 2'd2) : (pass_q == 2'd0);
    end

    always_comb begin
        busy       = (state_q == ST_ROUND);
        in_ready   = (state_q == ST_IDLE);
        out_valid  = (state_q == ST_DONE);
        out_block  = {l_q, r_q};
        f_r        = r_q;
        ks_round   = '0;
        ks_key_sel = 2'd0;
        ks_dec     = 1'b0;
        if (state_q == ST_ROUND) begin
            ks_round   = pass_enc ? rnd_q : (LAST_RND - rnd_q);
            ks_key_sel = tdes_q ? (enc_q ? pass_q : (2'd2 - pass_q)) : 2'd0;
            ks_dec     = !pass_enc;
        end
    end

    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        rnd_d   = rnd_q;
        pass_d  = pass_q;
        enc_d   = enc_q;
        tdes_d  = tdes_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    l_d     = in_block[2*HALF_W-1:HALF_W];
                    r_d     = in_block[HALF_W-1:0];
                    enc_d   = is_enc;
                    tdes_d  = tdes;
                    rnd_d   = '0;
                    pass_d  = 2'd0;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (last_rnd) begin
                    // no swap on the last round, so {L,R} feeds the next pass directly
                    l_d   = l_q ^ f_out;
                    rnd_d = '0;
                    if (last_pass) begin
                        state_d = ST_DONE;
                    end else begin
                        pass_d = pass_q + 2'd1;
                    end
                end else begin
                    l_d   = r_q;
                    r_d   = l_q ^ f_out;
                    rnd_d = rnd_q + RND_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            l_q     <= '0;
            r_q     <= '0;
            rnd_q   <= '0;
            pass_q  <= 2'd0;
            enc_q   <= 1'b0;
            tdes_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            rnd_q   <= rnd_d;
            pass_q  <= pass_d;
            enc_q   <= enc_d;
            tdes_q  <= tdes_d;
        end
    end
endmodule

// File: tb/tb_feistel_engine.sv
// tb/tb_feistel_engine.sv - self-checking bench: DES/3DES engine with external DES f, plus a small 8-bit/4-round instance
module tb_feistel_engine;
    localparam logic [63:0] KAT_K  = 64'h133457799BBCDFF1;
    localparam logic [63:0] KAT_PT = 64'h0123456789ABCDEF;
    localparam logic [63:0] KAT_CT = 64'h85E813540F0AB405;

    logic clk = 1'b0;
    logic b_reset = 1'b0;
    always #5 clk = ~clk;

    logic        b_in_valid = 1'b0, b_in_ready, b_is_enc = 1'b0, b_tdes = 1'b0;
    logic [63:0] b_in_block = '0, b_out_block;
    logic        b_out_valid, b_out_ready = 1'b0, b_ks_dec, b_busy;
    logic [3:0]  b_ks_round;
    logic [1:0]  b_ks_key_sel;
    logic [31:0] b_f_r, b_f_out;

    logic        s_in_valid = 1'b0, s_in_ready, s_is_enc = 1'b0, s_tdes = 1'b0;
    logic [15:0] s_in_block = '0, s_out_block;
    logic        s_out_valid, s_out_ready = 1'b0, s_ks_dec, s_busy;
    logic [1:0]  s_ks_round, s_ks_key_sel;
    logic [7:0]  s_f_r, s_f_out;

    feistel_engine u_big (
        .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_block(b_in_block), .is_enc(b_is_enc), .tdes(b_tdes), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_block(b_out_block), .ks_round(b_ks_round),
        .ks_key_sel(b_ks_key_sel), .ks_dec(b_ks_dec), .f_r(b_f_r), .f_out(b_f_out), .busy(b_busy)
    );

    feistel_engine #(.HALF_W(8), .ROUNDS(4)) u_small (
        .clk(clk), .reset(b_reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_block(s_in_block), .is_enc(s_is_enc), .tdes(s_tdes), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_block(s_out_block), .ks_round(s_ks_round),
        .ks_key_sel(s_ks_key_sel), .ks_dec(s_ks_dec), .f_r(s_f_r), .f_out(s_f_out), .busy(s_busy)
    );

    int ip_t [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6,
                      64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3,
                      61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    int e_t [48]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                      16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    int p_t [32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                      2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    int pc1_t [56] = '{57,49,41,33,25,17,9,1, 58,50,42,34,26,18,10,2, 59,51,43,35,27,19,11,3,
                       60,52,44,36,63,55,47,39, 31,23,15,7,62,54,46,38, 30,22,14,6,61,53,45,37,
                       29,21,13,5,28,20,12,4};
    int pc2_t [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                       41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    int sh_t [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    // one 64-bit word per S-box row, column 0 in the top nibble
    logic [63:0] sbox [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

    logic [47:0] subk [4][16];
    int n_checks = 0;
    int n_errors = 0;
    int ksr_q[$], sel_q[$], dec_q[$], bsy_q[$];

    function automatic logic [63:0] ip(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-ip_t[i]];
        return y;
    endfunction

    function automatic logic [63:0] inv_ip(input logic [63:0] y);
        logic [63:0] x;
        for (int i = 0; i < 64; i++) x[64-ip_t[i]] = y[63-i];
        return x;
    endfunction

    function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s, y;
        logic [5:0]  six;
        logic [63:0] row;
        for (int i = 0; i < 48; i++) x[47-i] = r[32-e_t[i]];
        x = x ^ k;
        for (int b = 0; b < 8; b++) begin
            six = x[47-6*b -: 6];
            row = sbox[4*b + 2*int'(six[5]) + int'(six[0])];
            s[31-4*b -: 4] = row[63-4*int'(six[4:1]) -: 4];
        end
        for (int i = 0; i < 32; i++) y[31-i] = s[32-p_t[i]];
        return y;
    endfunction

    task automatic make_subkeys(input int ki, input logic [63:0] key);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] k;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-pc1_t[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < sh_t[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) k[47-i] = cd[56-pc2_t[i]];
            subk[ki][r] = k;
        end
    endtask

    task automatic set_keys(input logic [63:0] k0, input logic [63:0] k1, input logic [63:0] k2);
        make_subkeys(0, k0);
        make_subkeys(1, k1);
        make_subkeys(2, k2);
        make_subkeys(3, 64'h0);
    endtask

    // textbook DES with IP/FP and the final swap
    function automatic logic [63:0] des_ref(input int ki, input logic [63:0] pt, input logic enc);
        logic [63:0] x;
        logic [31:0] l, r, t;
        x = ip(pt);
        l = x[63:32];
        r = x[31:0];
        for (int i = 0; i < 16; i++) begin
            t = r;
            r = l ^ des_f(r, enc ? subk[ki][i] : subk[ki][15-i]);
            l = t;
        end
        return inv_ip({r, l});
    endfunction

    function automatic logic [63:0] tdes_ref(input logic [63:0] x, input logic enc);
        if (enc) return des_ref(2, des_ref(1, des_ref(0, x, 1'b1), 1'b0), 1'b1);
        return des_ref(0, des_ref(1, des_ref(2, x, 1'b0), 1'b1), 1'b0);
    endfunction

    function automatic logic [15:0] small_ref(input logic [15:0] blk, input logic enc, input logic td);
        logic [7:0] l, r, f, t;
        logic dir;
        int k;
        l = blk[15:8];
        r = blk[7:0];
        for (int p = 0; p < (td ? 3 : 1); p++) begin
            dir = (td && p == 1) ? !enc : enc;
            for (int i = 0; i < 4; i++) begin
                k = dir ? i : 3 - i;
                f = r ^ 8'(k + 1);
                if (i < 3) begin
                    t = l; l = r; r = t ^ f;
                end else begin
                    l = l ^ f;
                end
            end
        end
        return {l, r};
    endfunction

    always_comb b_f_out = des_f(b_f_r, subk[b_ks_key_sel][b_ks_round]);
    always_comb s_f_out = s_f_r ^ 8'(int'(s_ks_round) + 1);

    task automatic run_big(input logic [63:0] blk, input logic enc, input logic td,
                           input logic keep_valid, output logic [63:0] res, output int lat);
        int w;
        ksr_q.delete(); sel_q.delete(); dec_q.delete(); bsy_q.delete();
        @(negedge clk);
        w = 0;
        while (!b_in_ready && w < 100) begin @(negedge clk); w++; end
        b_in_block = blk; b_is_enc = enc; b_tdes = td; b_in_valid = 1'b1; b_out_ready = 1'b0;
        @(posedge clk); #1;
        if (keep_valid) begin
            b_in_block = ~blk; b_is_enc = ~enc; b_tdes = ~td;
        end else begin
            b_in_valid = 1'b0;
        end
        lat = 0;
        while (!b_out_valid && lat < 200) begin
            ksr_q.push_back(int'(b_ks_round));
            sel_q.push_back(int'(b_ks_key_sel));
            dec_q.push_back(int'(b_ks_dec));
            bsy_q.push_back(int'(b_busy));
            @(posedge clk); #1;
            lat++;
        end
        res = b_out_block;
    endtask

    task automatic drain_big;
        @(negedge clk);
        b_out_ready = 1'b1; b_in_valid = 1'b0;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
    endtask

    task automatic test_reset;
        b_reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks += 8;
        if (b_in_ready !== 1'b1)   begin n_errors++; $display("FAIL reset_in_ready got %b want 1", b_in_ready); end
        if (b_out_valid !== 1'b0)  begin n_errors++; $display("FAIL reset_out_valid got %b want 0", b_out_valid); end
        if (b_busy !== 1'b0)       begin n_errors++; $display("FAIL reset_busy got %b want 0", b_busy); end
        if (b_out_block !== 64'h0) begin n_errors++; $display("FAIL reset_out_block got %h want 0", b_out_block); end
        if (b_ks_round !== 4'h0)   begin n_errors++; $display("FAIL reset_ks_round got %0d want 0", b_ks_round); end
        if (b_ks_key_sel !== 2'h0) begin n_errors++; $display("FAIL reset_ks_key_sel got %0d want 0", b_ks_key_sel); end
        if (b_ks_dec !== 1'b0)     begin n_errors++; $display("FAIL reset_ks_dec got %b want 0", b_ks_dec); end
        if (b_f_r !== 32'h0)       begin n_errors++; $display("FAIL reset_f_r got %h want 0", b_f_r); end
        @(negedge clk);
        b_reset = 1'b1;
    endtask

    task automatic test_des_kat;
        logic [63:0] res;
        int lat, bad;
        set_keys(KAT_K, KAT_K, KAT_K);
        for (int d = 0; d < 2; d++) begin
            run_big(ip(d == 0 ? KAT_PT : KAT_CT), (d == 0), 1'b0, 1'b0, res, lat);
            n_checks += 4;
            if (inv_ip(res) !== (d == 0 ? KAT_CT : KAT_PT))
                begin n_errors++; $display("FAIL des_kat_%0d result got %h", d, inv_ip(res)); end
            if (lat != 16) begin n_errors++; $display("FAIL des_kat_%0d latency got %0d want 16", d, lat); end
            bad = (ksr_q.size() != 16) ? 1 : 0;
            for (int i = 0; i < ksr_q.size() && i < 16; i++)
                if (ksr_q[i] != (d == 0 ? i : 15 - i) || bsy_q[i] != 1) bad++;
            if (bad != 0) begin n_errors++; $display("FAIL des_kat_%0d ks_round_seq bad entries %0d want 0", d, bad); end
            bad = 0;
            for (int i = 0; i < sel_q.size(); i++)
                if (sel_q[i] != 0 || dec_q[i] != (d == 0 ? 0 : 1)) bad++;
            if (bad != 0) begin n_errors++; $display("FAIL des_kat_%0d key_sel_dec bad entries %0d want 0", d, bad); end
            drain_big();
        end
    endtask

    task automatic test_tdes;
        logic [63:0] res;
        int lat, bad, p, r;
        logic dir;
        set_keys(KAT_K, KAT_K, KAT_K);
        for (int d = 0; d < 2; d++) begin
            run_big(ip(d == 0 ? KAT_PT : KAT_CT), (d == 0), 1'b1, 1'b0, res, lat);
            n_checks += 3;
            if (inv_ip(res) !== (d == 0 ? KAT_CT : KAT_PT))
                begin n_errors++; $display("FAIL tdes_kat_%0d result got %h", d, inv_ip(res)); end
            if (lat != 48) begin n_errors++; $display("FAIL tdes_kat_%0d latency got %0d want 48", d, lat); end
            bad = (sel_q.size() != 48) ? 1 : 0;
            for (int i = 0; i < sel_q.size() && i < 48; i++) begin
                p = i / 16;
                r = i % 16;
                dir = (d == 0) ? (p != 1) : (p == 1);
                if (sel_q[i] != (d == 0 ? p : 2 - p) || dec_q[i] != int'(!dir) ||
                    ksr_q[i] != (dir ? r : 15 - r)) bad++;
            end
            if (bad != 0) begin n_errors++; $display("FAIL tdes_kat_%0d pass_sequence bad entries %0d want 0", d, bad); end
            drain_big();
        end
    endtask

    task automatic test_random;
        logic [63:0] res, pt, exp;
        logic enc, td;
        int lat;
        for (int n = 0; n < 6; n++) begin
            set_keys({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
            pt  = {$urandom, $urandom};
            enc = 1'($urandom_range(1));
            td  = 1'($urandom_range(1));
            exp = td ? tdes_ref(pt, enc) : des_ref(0, pt, enc);
            run_big(ip(pt), enc, td, 1'b0, res, lat);
            n_checks += 2;
            if (inv_ip(res) !== exp) begin n_errors++; $display("FAIL random_%0d result got %h want %h", n, inv_ip(res), exp); end
            if (lat != (td ? 48 : 16)) begin n_errors++; $display("FAIL random_%0d latency got %0d", n, lat); end
            drain_big();
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] pt, exp;
        int acc[$];
        logic [63:0] outs[$];
        int bad;
        pt  = {$urandom, $urandom};
        exp = des_ref(0, pt, 1'b1);
        @(negedge clk);
        b_in_block = ip(pt); b_is_enc = 1'b1; b_tdes = 1'b0; b_in_valid = 1'b1; b_out_ready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (b_in_ready) acc.push_back(c);
            if (b_out_valid) outs.push_back(inv_ip(b_out_block));
            @(negedge clk);
        end
        b_in_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (b_out_valid) begin
                outs.push_back(inv_ip(b_out_block));
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        b_out_ready = 1'b0;
        n_checks += 2;
        bad = (acc.size() != 3) ? 1 : 0;
        for (int i = 1; i < acc.size(); i++) if (acc[i] - acc[i-1] != 18) bad++;
        if (bad != 0) begin n_errors++; $display("FAIL b2b_throughput accepts %0d bad gaps %0d want 3 accepts 18 apart", acc.size(), bad); end
        bad = (outs.size() != 3) ? 1 : 0;
        for (int i = 0; i < outs.size(); i++) if (outs[i] !== exp) bad++;
        if (bad != 0) begin n_errors++; $display("FAIL b2b_results outputs %0d bad %0d want 3 of %h", outs.size(), bad, exp); end
    endtask

    task automatic test_backpressure;
        logic [63:0] res, pt;
        int lat, bad_stable, bad_rdy;
        pt = {$urandom, $urandom};
        run_big(ip(pt), 1'b1, 1'b0, 1'b1, res, lat);
        n_checks += 2;
        if (inv_ip(res) !== des_ref(0, pt, 1'b1)) begin n_errors++; $display("FAIL bp_result got %h", inv_ip(res)); end
        if (lat != 16) begin n_errors++; $display("FAIL bp_latency got %0d want 16", lat); end
        bad_stable = 0;
        bad_rdy = 0;
        for (int c = 0; c < 5; c++) begin
            b_in_valid = ~b_in_valid;
            b_in_block = {$urandom, $urandom};
            @(posedge clk); #1;
            if (b_out_block !== res || b_out_valid !== 1'b1) bad_stable++;
            if (b_in_ready !== 1'b0 || b_busy !== 1'b0) bad_rdy++;
        end
        n_checks += 3;
        if (bad_stable != 0) begin n_errors++; $display("FAIL bp_hold_stable bad cycles %0d want 0", bad_stable); end
        if (bad_rdy != 0) begin n_errors++; $display("FAIL bp_in_ready_low bad cycles %0d want 0", bad_rdy); end
        b_out_ready = 1'b1; b_in_valid = 1'b0;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0)
            begin n_errors++; $display("FAIL bp_release in_ready %b out_valid %b want 1 0", b_in_ready, b_out_valid); end
    endtask

    task automatic test_reset_mid;
        logic [63:0] res;
        int lat;
        set_keys(KAT_K, KAT_K, KAT_K);
        @(negedge clk);
        b_in_block = ip({$urandom, $urandom}); b_is_enc = 1'b1; b_tdes = 1'b1; b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        n_checks += 2;
        if (b_ks_round !== 4'd7 || b_busy !== 1'b1)
            begin n_errors++; $display("FAIL rstmid_round7 ks_round %0d busy %b want 7 1", b_ks_round, b_busy); end
        b_reset = 1'b0;
        @(posedge clk); #1;
        b_reset = 1'b1;
        if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_out_block !== 64'h0 || b_busy !== 1'b0 || b_ks_round !== 4'd0)
            begin n_errors++; $display("FAIL rstmid_idle in_ready %b out_valid %b out_block %h busy %b want 1 0 0 0", b_in_ready, b_out_valid, b_out_block, b_busy); end
        run_big(ip(KAT_PT), 1'b1, 1'b0, 1'b0, res, lat);
        n_checks++;
        if (inv_ip(res) !== KAT_CT) begin n_errors++; $display("FAIL rstmid_fresh got %h want %h", inv_ip(res), KAT_CT); end
        drain_big();
    endtask

    task automatic test_param;
        logic [15:0] blk, exp;
        logic enc, td;
        int lat;
        for (int n = 0; n < 10; n++) begin
            blk = 16'($urandom);
            enc = 1'(n % 2);
            td  = 1'((n / 2) % 2);
            exp = small_ref(blk, enc, td);
            @(negedge clk);
            s_in_block = blk; s_is_enc = enc; s_tdes = td; s_in_valid = 1'b1;
            @(posedge clk); #1;
            s_in_valid = 1'b0;
            lat = 0;
            while (!s_out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
            n_checks += 2;
            if (s_out_block !== exp) begin n_errors++; $display("FAIL param_%0d result got %h want %h", n, s_out_block, exp); end
            if (lat != (td ? 12 : 4)) begin n_errors++; $display("FAIL param_%0d latency got %0d want %0d", n, lat, td ? 12 : 4); end
            @(negedge clk);
            s_out_ready = 1'b1;
            @(posedge clk); #1;
            s_out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_des_kat();
        test_tdes();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_param();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1);
    end
endmodule

// File: doc/feistel_engine.md
# feistel_engine

Parametrised, iterative Feistel round engine and the next generation of the DES datapath. It performs one Feistel round per clock over a configurable number of rounds. It also sequences single-DES or triple-DES (EDE) passes in either direction, using valid/ready handshakes on input and output. The round function (E/XOR/S-box/P) and the key schedule remain separate combinational blocks that this engine drives. Initial and final permutations are applied outside this block: `in_block` is post-IP and `out_block` is pre-FP.

## Interface
- `HALF_W`, 32: width of each Feistel half; block width is 2·HALF_W.
- `ROUNDS`, 16: rounds per pass, ≥2.
- `RND_W`, $clog2(ROUNDS): width of the round index.
- `clk`  in  1: single clock, all state on rising edge.
- `reset`  in  1: synchronous, active-low; sampled on rising edge of `clk`.
- `in_valid`  in  1: input block offered.
- `in_ready`  out  1: engine idle and able to accept.
- `in_block`  in  2·HALF_W: {L0,R0}, post-IP.
- `is_enc`  in  1: 1 = encrypt, 0 = decrypt; sampled at accept.
- `tdes`  in  1: 1 = three passes (EDE), 0 = one pass; sampled at accept.
- `out_valid`  out  1: result held on `out_block`.
- `out_ready`  in  1: consumer takes result.
- `out_block`  out  2·HALF_W: result, pre-FP.
- `ks_round`  out  RND_W: subkey index requested from the key schedule.
- `ks_key_sel`  out  2: which 64-bit key (0,1,2) the key schedule uses.
- `ks_dec`  out  1: direction of the current pass.
- `f_r`  out  HALF_W: right half presented to the round function.
- `f_out`  in  HALF_W: round-function result, combinational, same cycle.
- `busy`  out  1: high in ROUND state.

## Operation
- States: IDLE, ROUND, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: latch L=in_block[2·HALF_W-1:HALF_W] and R=lower half, latch `is_enc` and `tdes`, clear the round and pass counters, then go to ROUND.
- **ROUND:** each cycle, `f_r`=R.
  - Non-last round of a pass: L←R, R←L⊕f_out.
  - Last round of a pass (round counter = ROUNDS-1): L←L⊕f_out, R←R. There is no swap, so {L,R} is the DES pre-FP output and is directly the next pass's input.
  - Round counter wraps to 0 at the end of each pass, and the pass counter increments.
  - After the last round of the final pass (pass 0 single, pass 2 triple), go to DONE.
- **Pass direction and key**
  - Single: direction = `is_enc`, key 0.
  - Triple encrypt: passes enc/K0, dec/K1, enc/K2.
  - Triple decrypt: passes dec/K2, enc/K1, dec/K0.
  - `ks_dec` = !pass-direction.
- **Subkey index:** `ks_round` = round counter when encrypting the pass, ROUNDS-1-counter when decrypting.
- **DONE**
  - `out_valid`=1 and `out_block`={L,R}, held stable while `out_ready`=0.
  - On `out_ready`: go to IDLE.
  - `in_ready`=0 in DONE; there is no same-cycle turnaround.
- `in_valid` outside IDLE is ignored, and inputs are not re-sampled mid-operation.
- **Reset (any state, including mid-operation):** go to IDLE and zero L, R and all counters.
  - Outputs after reset: `in_ready`=1, `out_valid`=0, `busy`=0, `out_block`=0, `ks_round`=0, `ks_key_sel`=0, `ks_dec`=0, `f_r`=0.
  - A partially processed block is discarded.

## Timing
- Accept at edge E0; rounds execute on edges E1…EN, with N = ROUNDS (single) or 3·ROUNDS (triple).
- `out_valid` rises after EN: latency is 16 cycles for DES and 48 for 3DES at defaults.
- Throughput: one block per N+2 cycles when `out_ready` is held high.
- `ks_*` and `f_r` are registered-state decodes, valid for the whole cycle; `f_out` is combinational within that cycle.
- Counter arithmetic is modulo ROUNDS.
- The pass counter is 2 bits; only values 0–2 are legal.

## Test plan
- **Single-DES known answer:** DES encrypt with K0=133457799BBCDFF1, PT 0123456789ABCDEF, external IP/FP and round function → CT 85E813540F0AB405.
  - `out_valid` asserted exactly 16 cycles after accept.
  - `ks_round` sequence is 0..15.
- **Single-DES decrypt:** decrypt of 85E813540F0AB405 → 0123456789ABCDEF.
  - `ks_round` sequence is 15..0.
- **Triple-DES:** `tdes`=1 with K0=K1=K2=133457799BBCDFF1 → same CT as single DES.
  - Latency is 48 cycles.
  - `ks_key_sel`/`ks_dec` follow 0/0, 1/1, 2/0 per pass.
  - Decrypt restores the PT.
- **Back-pressure:** hold `out_ready`=0 for 5 cycles after `out_valid`.
  - `out_block` is stable and `in_ready`=0 throughout.
  - `in_valid` pulses during ROUND/DONE are not accepted.
  - Release → IDLE on the next edge.
- **Reset mid-operation:** drive `reset`=0 at round 7.
  - Next edge: IDLE, `out_valid`=0, `out_block`=0.
  - A fresh PT afterwards yields the correct CT.
- **Parametrisation:** `HALF_W`=8, `ROUNDS`=4, bench model f_out=R⊕(round+1).
  - Output matches the reference model.
  - Latency is 4 (single) and 12 (triple).
